task_11_in: RTL and testbench
=============================

TASK_11_IN -- requirements
Module: task_11_in

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of one payload word in bits.
REQ-002 Parameter DEPTH, default 32, words per packet buffer and maximum accepted packet length.
REQ-003 i_clk  input  1  single clock; all logic on its rising edge.
REQ-004 i_rst_n  input  1  reset, synchronous and active-low.
REQ-005 i_tmanager_data  input  DATA_WIDTH  payload word from the task manager.
REQ-006 i_tmanager_valid  input  1  i_tmanager_data is valid this cycle.
REQ-007 i_tmanager_last  input  1  final word of the packet; qualified by i_tmanager_valid.
REQ-008 o_tmanager_ready  output  1  block accepts a word this cycle.
REQ-009 i_out_full  input  1  downstream output stage cannot take a word this cycle.
REQ-010 o_data  output  DATA_WIDTH  word to the output stage.
REQ-011 o_data_valid  output  1  o_data is valid; one word per cycle.
REQ-012 o_input_last  output  1  o_data is the final word of the packet.
REQ-013 o_busy  output  1  a packet is in progress.
REQ-014 o_packet_size_in_bytes  output  12  word count of the current packet.
REQ-015 o_overflow  output  1  sticky flag: a packet longer than DEPTH was dropped.

Function
REQ-016 A word SHALL be accepted on a rising edge where i_tmanager_valid and o_tmanager_ready are both 1.
REQ-017 States: IDLE, RECV, DRAIN, DROP.
REQ-018 IDLE: o_tmanager_ready=1; an accepted word is written at address 0 and count becomes 1; next state is DRAIN if last, else RECV.
REQ-019 RECV: o_tmanager_ready=1 while count<DEPTH; each accepted word is written at address count and increments count; an accepted last moves to DRAIN.
REQ-020 RECV with count==DEPTH and no last seen: o_tmanager_ready SHALL be 0 for exactly one cycle, then the state SHALL move to DROP.
REQ-021 DROP: o_tmanager_ready=1; accepted words are discarded; an accepted last sets o_overflow, clears count, and returns to IDLE; no word is emitted downstream.
REQ-022 DRAIN: o_tmanager_ready=0; read pointer starts at 0.
REQ-023 DRAIN: on each edge with i_out_full=0, o_data<=buffer[rdptr], o_data_valid<=1, rdptr increments; with i_out_full=1, o_data_valid<=0 and rdptr holds.
REQ-024 The first o_data_valid SHALL appear one cycle after entry to DRAIN when i_out_full=0, i.e. 2 edges after the last word is accepted.
REQ-025 o_input_last SHALL be 1 with the word at address count-1 only, and the state SHALL return to IDLE on that same edge.
REQ-026 o_data_valid and o_input_last SHALL be registered, and SHALL be 0 in IDLE, RECV and DROP.
REQ-027 o_busy SHALL be 1 in RECV, DRAIN and DROP, and 0 in IDLE.
REQ-028 o_packet_size_in_bytes SHALL equal count zero-extended to 12 bits; it holds through DRAIN and clears on return to IDLE.
REQ-029 A 1-word packet (valid&last in IDLE) SHALL go directly to DRAIN and emit one word with o_input_last=1.
REQ-030 A packet of exactly DEPTH words whose last arrives on word DEPTH SHALL be accepted normally and SHALL NOT overflow.
REQ-031 i_tmanager_valid while o_tmanager_ready=0 SHALL have no effect; the task manager holds the word.
REQ-032 o_overflow SHALL stay set until reset.

Reset
REQ-033 While i_rst_n=0 on an edge: state=IDLE, count=0, rdptr=0, and all outputs 0 except o_tmanager_ready, which is 0 during reset and 1 from the first edge after release.
REQ-034 Reset mid-RECV or mid-DRAIN SHALL discard the packet; buffer contents need not be cleared.

Structure
REQ-035 Package task_11_pkg SHALL hold the state enum type and the DATA_WIDTH/DEPTH defaults.
REQ-036 Storage SHALL be a separate sub-module task_11_in_buf: a DEPTH x DATA_WIDTH register array with synchronous write and combinational read, and no vendor FIFO primitive.

Verification
REQ-037 5-word packet 0x11..0x15, i_out_full=0 -> o_data 0x11..0x15 on consecutive cycles, first word 2 edges after last is accepted; o_input_last with 0x15; o_packet_size_in_bytes=5.
REQ-038 Same packet with i_out_full=1 for 3 cycles mid-drain -> no word lost or duplicated; o_data_valid low exactly 3 cycles.
REQ-039 1-word packet 0xA5 -> one output with o_data_valid=1 and o_input_last=1; o_busy high for 2 cycles.
REQ-040 32-word packet -> all 32 emitted and o_overflow=0; 40-word packet -> ready low 1 cycle after word 32, nothing emitted, o_overflow=1, next 3-word packet handled normally.
REQ-041 i_rst_n=0 during DRAIN after 2 of 5 words -> outputs 0 on the next edge; a following 2-word packet is output correctly.

Source files
------------

// File: rtl/task_11_pkg.sv
// Shared types and default sizing for the task-manager input packet buffer.
package task_11_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DEPTH_DEF      = 32;
  localparam int SIZE_W         = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DROP  = 2'd3
  } state_e;

endpackage

// File: rtl/task_11_in_buf.sv
// Packet storage: DEPTH x DATA_WIDTH register array, synchronous write, combinational read.
module task_11_in_buf
  import task_11_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]         i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset; a packet is only read after it is written.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = mem_q[i_rd_addr];

endmodule

// File: rtl/task_11_in.sv
// Collects one packet from the task manager, then replays it to the output stage.
// Packets longer than DEPTH are swallowed and flagged in a sticky overflow bit.
module task_11_in
  import task_11_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_tmanager_data,
  input  logic                  i_tmanager_valid,
  input  logic                  i_tmanager_last,
  output logic                  o_tmanager_ready,
  input  logic                  i_out_full,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_valid,
  output logic                  o_input_last,
  output logic                  o_busy,
  output logic [SIZE_W-1:0]     o_packet_size_in_bytes,
  output logic                  o_overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Handshake: a word moves on a rising edge where i_tmanager_valid and
  // o_tmanager_ready are both 1; the manager holds data/last until then.
  // The output side has no ready: i_out_full=1 simply stalls the replay.

  state_e                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [AW-1:0]         rdptr_q, rdptr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  ovf_q, ovf_d;
  logic                  rdy_en_q;

  logic                  ready;
  logic                  accept;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_last;

  task_11_in_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_buf (
    .i_clk     (i_clk),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (i_tmanager_data),
    .i_rd_addr (rdptr_q),
    .o_rd_data (rd_data)
  );

  // rdy_en_q keeps ready low through reset and releases it one edge later.
  always_comb begin
    ready = 1'b0;
    case (state_q)
      ST_IDLE: ready = 1'b1;
      ST_RECV: ready = (count_q < DEPTH_C);
      ST_DROP: ready = 1'b1;
      default: ready = 1'b0;
    endcase
    ready = ready & rdy_en_q;
  end

  assign accept  = i_tmanager_valid & ready;
  assign rd_last = (CW'(rdptr_q) == (count_q - CW'(1)));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rdptr_d = '0;
    data_d  = data_q;
    valid_d = 1'b0;
    last_d  = 1'b0;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;
    wr_addr = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          wr_en   = 1'b1;
          count_d = CW'(1);
          state_d = i_tmanager_last ? ST_DRAIN : ST_RECV;
        end
      end
      ST_RECV: begin
        if (accept) begin
          wr_en   = 1'b1;
          wr_addr = count_q[AW-1:0];
          count_d = count_q + CW'(1);
          if (i_tmanager_last) begin
            state_d = ST_DRAIN;
          end
        end else if (count_q == DEPTH_C) begin
          // Buffer full without a last: spend this cycle with ready low, then discard.
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (accept && i_tmanager_last) begin
          ovf_d   = 1'b1;
          count_d = '0;
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        rdptr_d = rdptr_q;
        if (!i_out_full) begin
          data_d  = rd_data;
          valid_d = 1'b1;
          rdptr_d = rdptr_q + AW'(1);
          if (rd_last) begin
            last_d  = 1'b1;
            count_d = '0;
            rdptr_d = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      rdptr_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      ovf_q    <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rdptr_q  <= rdptr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      ovf_q    <= ovf_d;
      rdy_en_q <= 1'b1;
    end
  end

  assign o_tmanager_ready       = ready;
  assign o_data                 = data_q;
  assign o_data_valid           = valid_q;
  assign o_input_last           = last_q;
  // The packet stays busy while its final word is still presented downstream.
  assign o_busy                 = (state_q != ST_IDLE) | last_q;
  assign o_packet_size_in_bytes = SIZE_W'(count_q);
  assign o_overflow             = ovf_q;

endmodule

// File: tb/tb_task_11_in.sv
// Directed bench for task_11_in: packet capture, replay with stalls, overflow drop and reset.
module tb_task_11_in;

  logic        i_clk;
  logic        i_rst_n;
  logic [7:0]  i_tmanager_data;
  logic        i_tmanager_valid;
  logic        i_tmanager_last;
  logic        o_tmanager_ready;
  logic        i_out_full;
  logic [7:0]  o_data;
  logic        o_data_valid;
  logic        o_input_last;
  logic        o_busy;
  logic [11:0] o_packet_size_in_bytes;
  logic        o_overflow;

  int          vectors;
  int          errs;
  int          vld_count;
  int          first_lat;
  int          gaps;
  int          vbase;
  logic [7:0]  exp_q[$];

  task_11_in dut (
    .i_clk                  (i_clk),
    .i_rst_n                (i_rst_n),
    .i_tmanager_data        (i_tmanager_data),
    .i_tmanager_valid       (i_tmanager_valid),
    .i_tmanager_last        (i_tmanager_last),
    .o_tmanager_ready       (o_tmanager_ready),
    .i_out_full             (i_out_full),
    .o_data                 (o_data),
    .o_data_valid           (o_data_valid),
    .o_input_last           (o_input_last),
    .o_busy                 (o_busy),
    .o_packet_size_in_bytes (o_packet_size_in_bytes),
    .o_overflow             (o_overflow)
  );

  // Clock / watchdog
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

  always @(negedge i_clk) begin
    if (o_data_valid === 1'b1) vld_count++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Driver: present one word and hold it until the DUT takes it.
  task automatic send_word(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    i_tmanager_data  = d;
    i_tmanager_valid = 1'b1;
    i_tmanager_last  = l;
    while (o_tmanager_ready !== 1'b1 && n < 50) begin
      step(1);
      n++;
    end
    chk("ready_wait", 32'(o_tmanager_ready), 32'd1);
    step(1);
    i_tmanager_valid = 1'b0;
    i_tmanager_last  = 1'b0;
  endtask

  task automatic send_packet(input logic [7:0] base, input int n, input logic with_last,
                             input logic push);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = base + 8'(i);
      if (push) exp_q.push_back(d);
      send_word(d, with_last && (i == n - 1));
    end
  endtask

  // Scoreboard: drain n words, holding i_out_full high for fl edges starting at edge fs.
  task automatic collect(input int n, input int fs, input int fl,
                         output int lat, output int gp);
    int         cyc;
    int         got;
    logic [7:0] e;
    logic       el;
    cyc = 0;
    got = 0;
    lat = -1;
    gp  = 0;
    while (got < n && cyc < 300) begin
      i_out_full = (cyc >= fs && cyc < fs + fl);
      step(1);
      cyc++;
      if (o_data_valid === 1'b1) begin
        if (lat < 0) lat = cyc;
        e  = exp_q.pop_front();
        el = (exp_q.size() == 0);
        chk("out_data", 32'(o_data), 32'(e));
        chk("out_last", 32'(o_input_last), 32'(el));
        got++;
      end else if (lat >= 0) begin
        gp++;
      end
    end
    i_out_full = 1'b0;
    chk("words_out", 32'(got), 32'(n));
  endtask

  initial begin
    vectors          = 0;
    errs             = 0;
    vld_count        = 0;
    i_rst_n          = 1'b0;
    i_tmanager_data  = '0;
    i_tmanager_valid = 1'b0;
    i_tmanager_last  = 1'b0;
    i_out_full       = 1'b0;

    // Reset state
    step(2);
    chk("rst_ready", 32'(o_tmanager_ready), 32'd0);
    chk("rst_valid", 32'(o_data_valid), 32'd0);
    chk("rst_last", 32'(o_input_last), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_size", 32'(o_packet_size_in_bytes), 32'd0);
    chk("rst_ovf", 32'(o_overflow), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    i_rst_n = 1'b1;
    chk("ready_before_edge", 32'(o_tmanager_ready), 32'd0);
    step(1);
    chk("ready_after_release", 32'(o_tmanager_ready), 32'd1);

    // 5-word packet, no stall
    send_packet(8'h11, 5, 1'b1, 1'b1);
    chk("p5_size", 32'(o_packet_size_in_bytes), 32'd5);
    chk("p5_ready_drain", 32'(o_tmanager_ready), 32'd0);
    chk("p5_busy", 32'(o_busy), 32'd1);
    chk("p5_valid_entry", 32'(o_data_valid), 32'd0);
    collect(5, 0, 0, first_lat, gaps);
    chk("p5_first_latency", 32'(first_lat), 32'd1);
    chk("p5_gaps", 32'(gaps), 32'd0);
    chk("p5_size_cleared", 32'(o_packet_size_in_bytes), 32'd0);
    step(1);
    chk("p5_valid_idle", 32'(o_data_valid), 32'd0);
    chk("p5_busy_idle", 32'(o_busy), 32'd0);
    chk("p5_ready_idle", 32'(o_tmanager_ready), 32'd1);

    // Same packet with a 3-cycle stall mid-drain
    send_packet(8'h11, 5, 1'b1, 1'b1);
    collect(5, 2, 3, first_lat, gaps);
    chk("stall_first_latency", 32'(first_lat), 32'd1);
    chk("stall_gaps", 32'(gaps), 32'd3);
    chk("stall_queue_empty", 32'(exp_q.size()), 32'd0);
    step(1);

    // 1-word packet
    send_packet(8'hA5, 1, 1'b1, 1'b1);
    chk("p1_busy_c1", 32'(o_busy), 32'd1);
    chk("p1_size", 32'(o_packet_size_in_bytes), 32'd1);
    collect(1, 0, 0, first_lat, gaps);
    chk("p1_first_latency", 32'(first_lat), 32'd1);
    chk("p1_busy_c2", 32'(o_busy), 32'd1);
    step(1);
    chk("p1_busy_done", 32'(o_busy), 32'd0);

    // Exactly DEPTH words: accepted, no overflow
    send_packet(8'h00, 32, 1'b1, 1'b1);
    chk("p32_size", 32'(o_packet_size_in_bytes), 32'd32);
    collect(32, 0, 0, first_lat, gaps);
    chk("p32_gaps", 32'(gaps), 32'd0);
    chk("p32_ovf", 32'(o_overflow), 32'd0);
    step(1);

    // 40-word packet: dropped, overflow sticky
    vbase = vld_count;
    send_packet(8'h40, 32, 1'b0, 1'b0);
    chk("p40_ready_low", 32'(o_tmanager_ready), 32'd0);
    chk("p40_size_full", 32'(o_packet_size_in_bytes), 32'd32);
    i_tmanager_data  = 8'h60;
    i_tmanager_valid = 1'b1;
    step(1);
    chk("p40_ready_back", 32'(o_tmanager_ready), 32'd1);
    chk("p40_size_hold", 32'(o_packet_size_in_bytes), 32'd32);
    chk("p40_ovf_pending", 32'(o_overflow), 32'd0);
    send_packet(8'h60, 8, 1'b1, 1'b0);
    chk("p40_ovf_set", 32'(o_overflow), 32'd1);
    chk("p40_busy", 32'(o_busy), 32'd0);
    chk("p40_size_clr", 32'(o_packet_size_in_bytes), 32'd0);
    step(3);
    chk("p40_nothing_out", 32'(vld_count - vbase), 32'd0);
    send_packet(8'h71, 3, 1'b1, 1'b1);
    collect(3, 0, 0, first_lat, gaps);
    chk("p3_first_latency", 32'(first_lat), 32'd1);
    chk("p3_ovf_sticky", 32'(o_overflow), 32'd1);
    step(1);

    // Reset in the middle of a drain
    send_packet(8'h81, 5, 1'b1, 1'b1);
    collect(2, 0, 0, first_lat, gaps);
    i_rst_n = 1'b0;
    step(1);
    exp_q.delete();
    chk("mrst_valid", 32'(o_data_valid), 32'd0);
    chk("mrst_data", 32'(o_data), 32'd0);
    chk("mrst_busy", 32'(o_busy), 32'd0);
    chk("mrst_size", 32'(o_packet_size_in_bytes), 32'd0);
    chk("mrst_ready", 32'(o_tmanager_ready), 32'd0);
    chk("mrst_ovf", 32'(o_overflow), 32'd0);
    i_rst_n = 1'b1;
    step(1);
    chk("mrst_ready_back", 32'(o_tmanager_ready), 32'd1);
    send_packet(8'h3C, 2, 1'b1, 1'b1);
    collect(2, 0, 0, first_lat, gaps);
    chk("p2_first_latency", 32'(first_lat), 32'd1);
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
